// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM state encodings, word
// geometry and the word-index to byte-address mapping.
package prog_loader_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    ST_COUNT = 3'd0,
    ST_DATA  = 3'd1,
    ST_WRITE = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Byte address of word 'idx' in an image based at 'base', wrapping mod 2^32.
  function automatic logic [31:0] word_byte_addr(input logic [31:0] base,
                                                 input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/prog_loader_byte_packer.sv
// byte_packer: assembles accepted stream bytes into 32-bit little-endian
// words. The first byte of a word lands in bits 7:0. word_valid pulses in
// the same cycle as the handshake of the word's last byte, and 'word' is
// valid only in that cycle.
module byte_packer
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] sh_q, sh_d;

  // The first three bytes of a word are kept; the fourth completes it directly.
  assign word_valid = byte_valid & ~clear & (cnt_q == 2'(BYTES_PER_WORD - 1));
  assign word       = {byte_data, sh_q};

  // Next byte counter / shift register: new byte enters at the top.
  always_comb begin
    cnt_d = cnt_q;
    sh_d  = sh_q;
    if (clear) begin
      cnt_d = 2'd0;
    end else if (byte_valid) begin
      cnt_d = cnt_q + 2'd1;
      sh_d  = {byte_data, sh_q[23:8]};
    end
  end

  // Byte counter and partial-word storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 2'd0;
      sh_q  <= 24'd0;
    end else begin
      cnt_q <= cnt_d;
      sh_q  <= sh_d;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: receives a framed byte stream (word count, data words and,
// when LOADER_CHECKSUM_EN is defined, an XOR checksum trailer) and writes
// the words into CPU memory, holding the CPU until the image is complete.
// Words whose index falls beyond MEM_WORDS are consumed but not written,
// and flag load_err.
//
// state    | meaning
// ST_COUNT | collecting the 4 byte word count N
// ST_DATA  | collecting the bytes of the next data word
// ST_WRITE | memory write strobe cycle for the word just assembled
// ST_CHECK | collecting the checksum trailer word (checksum build only)
// ST_DONE  | image complete; CPU released unless load_err
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int BASE_ADDR = 0,
  parameter int CNT_W     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        load_start,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err,
  output logic [15:0] words_loaded
);

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS);
  localparam logic [31:0] BASE      = 32'(BASE_ADDR);
`ifdef LOADER_CHECKSUM_EN
  localparam state_e ST_AFTER = ST_CHECK;
`else
  localparam state_e ST_AFTER = ST_DONE;
`endif

  logic             pk_valid, pk_clear, pk_word_valid;
  logic [31:0]      pk_word;
  logic             idx_in_range;
  logic [CNT_W-1:0] idx_next;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic             cpu_hold_q, cpu_hold_d;
  logic             load_done_q, load_done_d;
  logic             load_err_q, load_err_d;
  logic [15:0]      words_loaded_q, words_loaded_d;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]      csum_q, csum_d;
`endif

  assign in_ready     = (state_q == ST_COUNT) | (state_q == ST_DATA) | (state_q == ST_CHECK);
  assign pk_valid     = in_valid & in_ready;
  assign pk_clear     = (state_q == ST_DONE) & load_start;
  assign idx_next     = idx_q + CNT_W'(1);
  assign idx_in_range = (32'(idx_q) < MEM_LIMIT);

  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign cpu_hold     = cpu_hold_q;
  assign load_done    = load_done_q;
  assign load_err     = load_err_q;
  assign words_loaded = words_loaded_q;

  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (pk_clear),
    .byte_valid (pk_valid),
    .byte_data  (in_data),
    .word_valid (pk_word_valid),
    .word       (pk_word)
  );

  // Next-state, counter, write-port and status computation.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    n_d            = n_q;
    mem_we_d       = 1'b0;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    load_err_d     = load_err_q;
    words_loaded_d = words_loaded_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d         = csum_q;
`endif
    unique case (state_q)
      ST_COUNT: begin
        if (pk_word_valid) begin
          n_d     = pk_word[CNT_W-1:0];
          idx_d   = '0;
          state_d = (pk_word[CNT_W-1:0] == '0) ? ST_AFTER : ST_DATA;
        end
      end
      ST_DATA: begin
        if (pk_word_valid) begin
          // Out-of-range words still go through WRITE so the stream stays aligned.
          mem_we_d    = idx_in_range;
          mem_addr_d  = word_byte_addr(BASE, 32'(idx_q));
          mem_wdata_d = pk_word;
          state_d     = ST_WRITE;
`ifdef LOADER_CHECKSUM_EN
          csum_d      = csum_q ^ pk_word;
`endif
        end
      end
      ST_WRITE: begin
        idx_d = idx_next;
        if (idx_in_range) begin
          words_loaded_d = words_loaded_q + 16'd1;
        end else begin
          load_err_d = 1'b1;
        end
        state_d = (idx_next < n_q) ? ST_DATA : ST_AFTER;
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (pk_word_valid) begin
          if (pk_word != csum_q) load_err_d = 1'b1;
          state_d = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        if (load_start) begin
          state_d        = ST_COUNT;
          idx_d          = '0;
          n_d            = '0;
          load_err_d     = 1'b0;
          words_loaded_d = 16'd0;
`ifdef LOADER_CHECKSUM_EN
          csum_d         = 32'd0;
`endif
        end
      end
      default: state_d = ST_COUNT;
    endcase
    load_done_d = (state_d == ST_DONE);
    cpu_hold_d  = ~((state_d == ST_DONE) & ~load_err_d);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_COUNT;
      idx_q          <= '0;
      n_q            <= '0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= 32'd0;
      mem_wdata_q    <= 32'd0;
      cpu_hold_q     <= 1'b1;
      load_done_q    <= 1'b0;
      load_err_q     <= 1'b0;
      words_loaded_q <= 16'd0;
`ifdef LOADER_CHECKSUM_EN
      csum_q         <= 32'd0;
`endif
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      n_q            <= n_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      cpu_hold_q     <= cpu_hold_d;
      load_done_q    <= load_done_d;
      load_err_q     <= load_err_d;
      words_loaded_q <= words_loaded_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q         <= csum_d;
`endif
    end
  end

endmodule
